// File: rtl/ram_initiator_pkg.sv
// Shared types and defaults for the RAM initiator: FSM state encoding and bus widths.
package ram_initiator_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W      = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RSP     = 3'd4
  } state_e;
endpackage

// File: rtl/ram_initiator_if.sv
// Request/response handshake plus RAM-side bus for the RAM initiator.
interface ram_initiator_if
  import ram_initiator_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requester + RAM side: issues requests, consumes responses, returns read data.
  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last, mem_addr, mem_we, mem_re, mem_wdata
  );

  // The initiator block itself.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_last, mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/ram_initiator.sv
// Single-port RAM initiator: single-cycle writes and 1-4 beat read bursts with a
// registered-output RAM, one outstanding request at a time.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  ram_initiator_if.slave bus
);

  state_e            state, nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  beats_left;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) nxt = bus.req_write ? WR : RD_ADDR;
      WR:      nxt = IDLE;
      RD_ADDR: nxt = RD_DATA;
      RD_DATA: nxt = RSP;
      RSP:     if (bus.rsp_ready) nxt = (beats_left == '0) ? IDLE : RD_ADDR;
      default: nxt = IDLE;
    endcase
  end

  // Address/beat counters and response capture; mem_rdata is only looked at in RD_DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      wdata_q    <= '0;
      beats_left <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          cur_addr <= bus.req_addr;
          if (bus.req_write) wdata_q    <= bus.req_wdata;
          else               beats_left <= bus.req_len;
        end
        RD_DATA: begin
          rsp_data_q <= bus.mem_rdata;
          rsp_last_q <= (beats_left == '0);
        end
        RSP: if (bus.rsp_ready && beats_left != '0) begin
          beats_left <= beats_left - LEN_W'(1);
          cur_addr   <= cur_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state == WR);
  assign bus.mem_re    = (state == RD_ADDR) || (state == RD_DATA);

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator with a 16x8 registered-output RAM and a
// transaction-level model checked every cycle.
module tb_ram_initiator;
  import ram_initiator_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) b();
  ram_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM: data registered on a read-enabled edge, bus floats when not reading.
  logic [DW-1:0] ram [16] = '{0: 8'h1A, 1: 8'h2B, 14: 8'h0A, 15: 8'h0B, default: 8'h00};
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (b.mem_we) ram[b.mem_addr] <= b.mem_wdata;
    if (b.mem_re) ram_q <= ram[b.mem_addr];
  end
  assign b.mem_rdata = b.mem_re ? ram_q : 'z;

  // Model: a queue of expected beats; each beat is due 3 falling edges after the
  // falling edge that sees the accepting request or the previous handshake.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic l; } beat_t;
  beat_t         mq[$];
  logic [DW-1:0] shadow [16] = '{0: 8'h1A, 1: 8'h2B, 14: 8'h0A, 15: 8'h0B, default: 8'h00};
  int            cyc = 0, due = 0, wr_cyc = -10;
  logic [AW-1:0] wr_a, ad;
  logic [DW-1:0] wr_d;
  logic          exp_rv, exp_re;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      wr_cyc = -10;
      due = 0;
    end else begin
      cyc++;
      exp_rv = (mq.size() > 0) && (cyc >= due);
      exp_re = (mq.size() > 0) && (cyc < due);
      chk("rsp_valid", b.rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rsp_data", b.rsp_data, mq[0].d);
        chk("rsp_last", b.rsp_last, mq[0].l);
      end
      chk("req_ready", b.req_ready, (mq.size() == 0) && (cyc != wr_cyc));
      chk("mem_we", b.mem_we, cyc == wr_cyc);
      if (cyc == wr_cyc) begin
        chk("wr_mem_addr", b.mem_addr, wr_a);
        chk("wr_mem_wdata", b.mem_wdata, wr_d);
      end
      chk("mem_re", b.mem_re, exp_re);
      if (exp_re) chk("rd_mem_addr", b.mem_addr, mq[0].a);
      chk("we_re_excl", b.mem_we && b.mem_re, 0);

      if (b.req_valid && b.req_ready) begin
        if (b.req_write) begin
          shadow[b.req_addr] = b.req_wdata;
          wr_cyc = cyc + 1;
          wr_a = b.req_addr;
          wr_d = b.req_wdata;
        end else begin
          for (int i = 0; i <= int'(b.req_len); i++) begin
            ad = b.req_addr + AW'(i);
            mq.push_back('{a: ad, d: shadow[ad], l: (i == int'(b.req_len))});
          end
          due = cyc + 3;
        end
      end
      if (b.rsp_valid && b.rsp_ready && mq.size() > 0) begin
        void'(mq.pop_front());
        due = cyc + 3;
      end
    end
  end

  always @(negedge clk)
    if (rst_n) assert (!(b.mem_we && b.mem_re)) else $error("mem_we and mem_re both high");

  int            last_waits, nb, first_v, stalls;
  logic [DW-1:0] got_d [4];
  logic          got_l [4];

  // Offer a request from posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [1:0] l,
                       input logic [DW-1:0] d);
    int n = 0;
    logic acc = 1'b0;
    b.req_valid = 1'b1; b.req_write = w; b.req_addr = a; b.req_len = l; b.req_wdata = d;
    while (!acc && n < 32) begin
      @(negedge clk);
      acc = b.req_ready;
      if (!acc) n++;
      @(posedge clk); #1;
    end
    b.req_valid = 1'b0;
    last_waits = n;
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  // Read burst; beat sb (if any) is held off for sn valid cycles with rsp_ready=0.
  task automatic read_burst(input logic [AW-1:0] a, input logic [1:0] l,
                            input int sb, input int sn);
    int budget = 0;
    int waits = 0;
    logic [DW-1:0] held = '0;
    nb = 0; first_v = -1;
    issue(1'b0, a, l, '0);
    while (nb <= int'(l) && budget < 64) begin
      b.rsp_ready = !(nb == sb && waits < sn);
      @(negedge clk);
      budget++;
      if (b.rsp_valid) begin
        if (first_v < 0) first_v = budget;
        if (b.rsp_ready) begin
          got_d[nb] = b.rsp_data;
          got_l[nb] = b.rsp_last;
          nb++;
        end else begin
          if (waits == 0) held = b.rsp_data;
          else chk("stall_rsp_data", b.rsp_data, held);
          chk("stall_mem_re", b.mem_re, 0);
          chk("stall_req_ready", b.req_ready, 0);
          waits++;
        end
      end
      @(posedge clk); #1;
    end
    b.rsp_ready = 1'b1;
    if (budget >= 64) chk("burst_timeout", nb, int'(l) + 1);
    stalls = waits;
  endtask

  initial begin
    int n;
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0; b.req_len = '0;
    b.req_wdata = '0; b.rsp_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", b.req_ready, 1);
    chk("rst_rsp_valid", b.rsp_valid, 0);
    chk("rst_mem_we", b.mem_we, 0);
    chk("rst_mem_re", b.mem_re, 0);
    chk("rst_mem_addr", b.mem_addr, 0);
    chk("rst_rsp_data", b.rsp_data, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // single-beat read, latency and data
    read_burst(4'd0, 2'd0, -1, 0);
    chk("t1_accept_first_edge", last_waits, 0);
    chk("t1_first_valid_edge", first_v, 3);
    chk("t1_beats", nb, 1);
    chk("t1_data", got_d[0], 8'h1A);
    chk("t1_last", got_l[0], 1);

    // 4-beat wrapping burst with a 5-cycle stall on beat 2
    read_burst(4'd14, 2'd3, 1, 5);
    chk("t2_beats", nb, 4);
    chk("t2_d0", got_d[0], 8'h0A);
    chk("t2_d1", got_d[1], 8'h0B);
    chk("t2_d2", got_d[2], 8'h1A);
    chk("t2_d3", got_d[3], 8'h2B);
    chk("t2_last_pattern", {got_l[0], got_l[1], got_l[2], got_l[3]}, 4'b0001);
    chk("t2_stall_cycles", stalls, 5);

    // write then read back
    issue(1'b1, 4'd0, 2'd0, 8'hAA);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (b.mem_we) n++;
    end
    chk("t3_we_cycles", n, 1);
    @(posedge clk); #1;
    read_burst(4'd0, 2'd0, -1, 0);
    chk("t3_data", got_d[0], 8'hAA);

    // read offered during a write is held off one cycle, then sees the new data
    issue(1'b1, 4'd3, 2'd0, 8'h5C);
    read_burst(4'd3, 2'd0, -1, 0);
    chk("t4_holdoff_waits", last_waits, 1);
    chk("t4_data", got_d[0], 8'h5C);
    chk("t4_last", got_l[0], 1);

    // async reset in RD_DATA aborts the burst
    issue(1'b0, 4'd14, 2'd3, '0);
    @(posedge clk); #1;
    chk("t5_in_rd_data_mem_re", b.mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_req_ready", b.req_ready, 1);
    chk("t5_rst_rsp_valid", b.rsp_valid, 0);
    chk("t5_rst_rsp_last", b.rsp_last, 0);
    chk("t5_rst_rsp_data", b.rsp_data, 0);
    chk("t5_rst_mem_we", b.mem_we, 0);
    chk("t5_rst_mem_re", b.mem_re, 0);
    chk("t5_rst_mem_addr", b.mem_addr, 0);
    chk("t5_rst_mem_wdata", b.mem_wdata, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    read_burst(4'd1, 2'd0, -1, 0);
    chk("t5_accept_first_edge", last_waits, 0);
    chk("t5_data", got_d[0], 8'h2B);
    chk("t5_last", got_l[0], 1);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
